// File: rtl/sdram_responder_if.sv
// Chip-side SDR SDRAM pins plus the responder's status outputs.
// The master modport is the controller side, the slave modport is the responder.
interface sdram_responder_if;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic [1:0]  sd_dqm;
  logic        sd_cs;
  logic        sd_ras;
  logic        sd_cas;
  logic        sd_we;
  logic [15:0] sd_data_in;
  logic [15:0] sd_data_out;
  logic        sd_data_oe;
  logic        mode_valid;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] refresh_cnt;

  modport master (
    output sd_addr, sd_ba, sd_dqm, sd_cs, sd_ras, sd_cas, sd_we, sd_data_in,
    input  sd_data_out, sd_data_oe, mode_valid, err, err_code, refresh_cnt
  );

  modport slave (
    input  sd_addr, sd_ba, sd_dqm, sd_cs, sd_ras, sd_cas, sd_we, sd_data_in,
    output sd_data_out, sd_data_oe, mode_valid, err, err_code, refresh_cnt
  );
endinterface

// File: rtl/sdram_responder.sv
// Single-chip SDR SDRAM device model: command decode, per-bank row tracking,
// mode register, CL-delayed read return and sticky protocol-error reporting.
module sdram_responder #(
  parameter int MEM_AW = 16,
  parameter int RCD    = 2,
  parameter int RP     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  sdram_responder_if.slave   sd
);

  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  cmd_e cmd;
  assign cmd = cmd_e'({sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we});

  // Bank state
  logic [3:0]        open_q,    open_d;
  logic [3:0][12:0]  row_q,     row_d;
  logic [3:0][2:0]   act_cnt_q, act_cnt_d;
  logic [3:0][2:0]   pre_cnt_q, pre_cnt_d;

  // Mode / status
  logic [1:0]  cl_q,   cl_d;
  logic        mv_q,   mv_d;
  logic        err_q,  err_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] ref_q,  ref_d;

  // Read return path: entry [0] feeds the output register next edge,
  // entry [1] only holds reads when CL=3.
  logic [1:0]        pvld_q, pvld_d;
  logic [1:0][15:0]  pdat_q;
  logic [15:0]       dout_q, dout_d;
  logic              oe_q,   oe_d;

  logic [2:0] ecode;
  logic       rd_en, wr_en;

  logic [15:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] maddr;

  // Physical address {ba,row,col} truncated to the array size
  assign maddr = MEM_AW'({sd.sd_ba, row_q[sd.sd_ba], sd.sd_addr[8:0]});

  // Next-state decode for one command per cycle
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    cl_d   = cl_q;
    mv_d   = mv_q;
    err_d  = err_q;
    code_d = code_q;
    ref_d  = ref_q;
    ecode  = 3'd0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      act_cnt_d[b] = (act_cnt_q[b] == 3'd7) ? 3'd7 : act_cnt_q[b] + 3'd1;
      pre_cnt_d[b] = (pre_cnt_q[b] == 3'd7) ? 3'd7 : pre_cnt_q[b] + 3'd1;
    end
    pvld_d = {1'b0, pvld_q[1]};
    oe_d   = pvld_q[0];
    dout_d = pvld_q[0] ? pdat_q[0] : 16'h0000;

    case (cmd)
      CMD_LMR: begin
        if (|open_q) ecode = 3'd1;
        else begin
          mv_d = 1'b1;
          // Unsupported latencies fall back to the slowest supported one
          cl_d = (sd.sd_addr[6:4] == 3'd2) ? 2'd2 : 2'd3;
          if (!(sd.sd_addr[6:4] == 3'd2 || sd.sd_addr[6:4] == 3'd3) ||
              sd.sd_addr[2:0] != 3'd0)
            ecode = 3'd2;
        end
      end
      CMD_ACT: begin
        if (open_q[sd.sd_ba]) ecode = 3'd1;
        else begin
          if (int'(pre_cnt_q[sd.sd_ba]) + 1 < RP) ecode = 3'd3;
          open_d[sd.sd_ba]    = 1'b1;
          row_d[sd.sd_ba]     = sd.sd_addr;
          act_cnt_d[sd.sd_ba] = 3'd0;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!mv_q) ecode = 3'd4;
        else if (!open_q[sd.sd_ba]) ecode = 3'd1;
        else begin
          if (int'(act_cnt_q[sd.sd_ba]) + 1 < RCD) ecode = 3'd3;
          else if (cmd == CMD_WR && oe_q) ecode = 3'd5;
          if (cmd == CMD_RD) rd_en = 1'b1;
          else               wr_en = 1'b1;
          if (sd.sd_addr[10]) begin
            open_d[sd.sd_ba]    = 1'b0;
            pre_cnt_d[sd.sd_ba] = 3'd0;
          end
        end
      end
      CMD_PRE: begin
        for (int b = 0; b < 4; b++)
          if (sd.sd_addr[10] || sd.sd_ba == 2'(b)) begin
            open_d[b]    = 1'b0;
            pre_cnt_d[b] = 3'd0;
          end
      end
      CMD_REF: begin
        if (|open_q) ecode = 3'd1;
        else if (ref_q != 16'hFFFF) ref_d = ref_q + 16'd1;
      end
      CMD_BST: ecode = 3'd6;
      default: ;
    endcase

    // Insert the read so it reaches the output register at edge N+CL-1
    if (rd_en) begin
      if (cl_q == 2'd2) pvld_d[0] = 1'b1;
      else              pvld_d[1] = 1'b1;
    end

    if (ecode != 3'd0 && !err_q) begin
      err_d  = 1'b1;
      code_d = ecode;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_q    <= '0;
      row_q     <= '0;
      act_cnt_q <= {4{3'd7}};
      pre_cnt_q <= {4{3'd7}};
      cl_q      <= 2'd2;
      mv_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 3'd0;
      ref_q     <= 16'd0;
      pvld_q    <= '0;
      dout_q    <= 16'd0;
      oe_q      <= 1'b0;
    end else begin
      open_q    <= open_d;
      row_q     <= row_d;
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      cl_q      <= cl_d;
      mv_q      <= mv_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ref_q     <= ref_d;
      pvld_q    <= pvld_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
    end
  end

  // Backing array and read-data pipeline; validity is tracked in pvld_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!sd.sd_dqm[0]) mem[maddr][7:0]  <= sd.sd_data_in[7:0];
      if (!sd.sd_dqm[1]) mem[maddr][15:8] <= sd.sd_data_in[15:8];
    end
    pdat_q[1] <= mem[maddr];
    pdat_q[0] <= (rd_en && cl_q == 2'd2) ? mem[maddr] : pdat_q[1];
  end

  assign sd.sd_data_out = dout_q;
  assign sd.sd_data_oe  = oe_q;
  assign sd.mode_valid  = mv_q;
  assign sd.err         = err_q;
  assign sd.err_code    = code_q;
  assign sd.refresh_cnt = ref_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: one command per cycle driven on the
// falling edge, outputs sampled 1ns after the rising edge.
module tb_sdram_responder;
  localparam logic [3:0] LMR = 4'b0000, REF = 4'b0001, PRE = 4'b0010,
                         ACT = 4'b0011, WR  = 4'b0100, RD  = 4'b0101,
                         BST = 4'b0110, NOP = 4'b0111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  sdram_responder_if sd ();

  sdram_responder #(.MEM_AW(16), .RCD(2), .RP(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sd      (sd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] ba,
                       input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
    {sd.sd_cs, sd.sd_ras, sd.sd_cas, sd.sd_we} = c;
    sd.sd_ba = ba; sd.sd_addr = a; sd.sd_data_in = d; sd.sd_dqm = m;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] ba,
                       input logic [12:0] a, input logic [15:0] d, input logic [1:0] m);
    @(negedge clk);
    drive(c, ba, a, d, m);
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(NOP, 2'd0, 13'd0, 16'd0, 2'b11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b11);
    #1;
    chk("rst_oe",   32'(sd.sd_data_oe),  32'd0);
    chk("rst_dout", 32'(sd.sd_data_out), 32'd0);
    chk("rst_mv",   32'(sd.mode_valid),  32'd0);
    chk("rst_err",  32'(sd.err),         32'd0);
    chk("rst_code", 32'(sd.err_code),    32'd0);
    chk("rst_ref",  32'(sd.refresh_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // CL=2 write then read
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    chk("t1_mv", 32'(sd.mode_valid), 32'd1);
    issue(ACT, 2'd1, 13'h0123, 16'd0, 2'b00);
    nop(); nop();
    issue(WR, 2'd1, 13'h045, 16'hBEEF, 2'b00);
    issue(RD, 2'd1, 13'h045, 16'd0, 2'b11);
    chk("t1_oe_n", 32'(sd.sd_data_oe), 32'd0);
    nop();
    chk("t1_oe", 32'(sd.sd_data_oe), 32'd1);
    chk("t1_dat", 32'(sd.sd_data_out), 32'hBEEF);
    nop();
    chk("t1_oe_off", 32'(sd.sd_data_oe), 32'd0);
    chk("t1_err", 32'(sd.err), 32'd0);

    // CL=3 with a masked byte write
    do_reset();
    issue(LMR, 2'd0, 13'h230, 16'd0, 2'b00);
    issue(ACT, 2'd1, 13'h0123, 16'd0, 2'b00);
    nop(); nop();
    issue(WR, 2'd1, 13'h045, 16'h1111, 2'b00);
    issue(WR, 2'd1, 13'h045, 16'hAAEF, 2'b10);
    issue(RD, 2'd1, 13'h045, 16'd0, 2'b00);
    chk("t2_oe0", 32'(sd.sd_data_oe), 32'd0);
    nop();
    chk("t2_oe1", 32'(sd.sd_data_oe), 32'd0);
    nop();
    chk("t2_oe2", 32'(sd.sd_data_oe), 32'd1);
    chk("t2_dat", 32'(sd.sd_data_out), 32'h11EF);
    nop();
    chk("t2_oe3", 32'(sd.sd_data_oe), 32'd0);
    chk("t2_err", 32'(sd.err), 32'd0);

    // RCD violation still returns data; later error does not overwrite code
    do_reset();
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    issue(ACT, 2'd0, 13'h0010, 16'd0, 2'b00);
    nop(); nop();
    issue(WR, 2'd0, 13'h000, 16'h5A5A, 2'b00);
    issue(PRE, 2'd0, 13'h000, 16'd0, 2'b00);
    nop();
    issue(ACT, 2'd0, 13'h0010, 16'd0, 2'b00);
    chk("t3_err_pre", 32'(sd.err), 32'd0);
    issue(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    chk("t3_err", 32'(sd.err), 32'd1);
    chk("t3_code", 32'(sd.err_code), 32'd3);
    nop();
    chk("t3_oe", 32'(sd.sd_data_oe), 32'd1);
    chk("t3_dat", 32'(sd.sd_data_out), 32'h5A5A);
    issue(BST, 2'd0, 13'h000, 16'd0, 2'b00);
    chk("t3_sticky", 32'(sd.err_code), 32'd3);

    // READ to idle bank
    do_reset();
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    issue(RD, 2'd2, 13'h000, 16'd0, 2'b00);
    chk("t4_code", 32'(sd.err_code), 32'd1);
    nop();
    chk("t4_oe1", 32'(sd.sd_data_oe), 32'd0);
    nop();
    chk("t4_oe2", 32'(sd.sd_data_oe), 32'd0);

    // ACTIVE to an open bank
    do_reset();
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    issue(ACT, 2'd3, 13'h0005, 16'd0, 2'b00);
    chk("t4b_ok", 32'(sd.err), 32'd0);
    issue(ACT, 2'd3, 13'h0006, 16'd0, 2'b00);
    chk("t4b_code", 32'(sd.err_code), 32'd1);

    // READ before LOAD_MODE
    do_reset();
    issue(ACT, 2'd0, 13'h0001, 16'd0, 2'b00);
    nop(); nop();
    issue(RD, 2'd0, 13'h000, 16'd0, 2'b00);
    chk("t4c_code", 32'(sd.err_code), 32'd4);

    // Unsupported CL
    do_reset();
    issue(LMR, 2'd0, 13'h250, 16'd0, 2'b00);
    chk("t4d_mv", 32'(sd.mode_valid), 32'd1);
    chk("t4d_code", 32'(sd.err_code), 32'd2);

    // Write while read data is on the bus
    do_reset();
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    issue(ACT, 2'd2, 13'h0001, 16'd0, 2'b00);
    nop(); nop();
    issue(RD, 2'd2, 13'h003, 16'd0, 2'b00);
    nop();
    issue(WR, 2'd2, 13'h003, 16'h7777, 2'b00);
    chk("t4e_code", 32'(sd.err_code), 32'd5);

    // Refresh counting
    do_reset();
    issue(REF, 2'd0, 13'h000, 16'd0, 2'b00);
    issue(REF, 2'd0, 13'h000, 16'd0, 2'b00);
    issue(REF, 2'd0, 13'h000, 16'd0, 2'b00);
    chk("t5_ref3", 32'(sd.refresh_cnt), 32'd3);
    chk("t5_err0", 32'(sd.err), 32'd0);
    issue(ACT, 2'd0, 13'h0001, 16'd0, 2'b00);
    issue(REF, 2'd0, 13'h000, 16'd0, 2'b00);
    chk("t5_ref_hold", 32'(sd.refresh_cnt), 32'd3);
    chk("t5_code", 32'(sd.err_code), 32'd1);

    // Back-to-back reads then reset mid-stream
    do_reset();
    issue(LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    issue(ACT, 2'd1, 13'h0123, 16'd0, 2'b00);
    nop(); nop();
    issue(WR, 2'd1, 13'h046, 16'h2222, 2'b00);
    issue(RD, 2'd1, 13'h045, 16'd0, 2'b00);
    issue(RD, 2'd1, 13'h046, 16'd0, 2'b00);
    chk("t6_oe_a", 32'(sd.sd_data_oe), 32'd1);
    chk("t6_dat_a", 32'(sd.sd_data_out), 32'h11EF);
    nop();
    chk("t6_oe_b", 32'(sd.sd_data_oe), 32'd1);
    chk("t6_dat_b", 32'(sd.sd_data_out), 32'h2222);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_oe", 32'(sd.sd_data_oe), 32'd0);
    chk("t6_rst_dout", 32'(sd.sd_data_out), 32'd0);
    chk("t6_rst_mv", 32'(sd.mode_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nop();
      chk("t6_post_oe", 32'(sd.sd_data_oe), 32'd0);
    end
    chk("t6_post_mv", 32'(sd.mode_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable single-chip SDR SDRAM responder, the device end of the sdram controller's chip interface.
- Decodes cs/ras/cas/we commands, tracks per-bank open rows and the mode register, and serves reads and writes from an internal word array.
- Flags protocol violations (timing, state, unsupported features) so controller changes can be checked in simulation and in FPGA loopback builds without a physical chip.

Parameters:
- MEM_AW, 16, word-address width of the backing array (2^MEM_AW x 16 bit); physical address {ba,row,col} is truncated to its low MEM_AW bits.
- RCD, 2, minimum cycles between ACTIVE and READ/WRITE to the same bank.
- RP, 2, minimum cycles between PRECHARGE and ACTIVE to the same bank.

Ports:
- clk, input, 1: sdram clock; all state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- sd_addr, input, 13: multiplexed row/column/mode address.
- sd_ba, input, 2: bank select.
- sd_dqm, input, 2: byte masks; [1] is the upper byte, [0] the lower byte.
- sd_cs, sd_ras, sd_cas, sd_we, input, 1 each: command pins, active low.
- sd_data_in, input, 16: write data from the controller.
- sd_data_out, output, 16: read data to the controller.
- sd_data_oe, output, 1: high while the responder drives read data.
- mode_valid, output, 1: a LOAD_MODE has been accepted.
- err, output, 1: sticky protocol-error flag.
- err_code, output, 3: code of the first error recorded.
- refresh_cnt, output, 16: saturating count of AUTO_REFRESH commands.

Behaviour:
- Reset (async assert, sync release):
  - All banks idle; mode_valid=0; CL=2.
  - sd_data_out=0, sd_data_oe=0, err=0, err_code=0, refresh_cnt=0.
  - Read pipeline flushed; in-flight reads are discarded; array contents are not cleared.
- Command decode: cmd={cs,ras,cas,we} is sampled each rising edge (cycle N).
  - 1xxx INHIBIT, 0111 NOP: no action.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
  - 0110 BURST_TERMINATE: error code 6.
- Per bank: open flag, 13-bit row, 3-bit cycles-since-ACTIVE counter and 3-bit cycles-since-PRECHARGE counter. Both counters saturate at 7 and start saturated after reset.
- LOAD_MODE:
  - Rejected unless all banks are idle (code 1).
  - Otherwise CL=sd_addr[6:4] and mode_valid=1.
  - CL values other than 2 or 3, or burst length sd_addr[2:0]!=000, give code 2. CL is still stored but clamped to 3.
- ACTIVE:
  - Bank already open: code 1, no state change.
  - Fewer than RP cycles since that bank's PRECHARGE: code 3, but the ACTIVE still takes effect.
  - Otherwise the bank opens, row=sd_addr, counter cleared.
- READ/WRITE:
  - mode_valid=0: code 4, command ignored.
  - Bank idle: code 1, command ignored.
  - Fewer than RCD cycles since ACTIVE: code 3, access still performed.
  - Column = sd_addr[8:0].
  - sd_addr[10]=1: auto-precharge; the bank closes after the access and its precharge counter clears.
- WRITE:
  - Array word updated at edge N.
  - Each byte lane is written only where its sd_dqm bit is 0.
  - A read issued at N-1 or earlier and not yet returned is unaffected.
- READ:
  - Data is fetched at edge N into a CL-deep pipeline and presented on sd_data_out with sd_data_oe=1 for exactly the one cycle ending at edge N+CL.
  - sd_data_out/oe update at edge N+CL-1; oe drops at edge N+CL unless another read follows.
  - DQM is ignored for reads.
  - Back-to-back READs return data on consecutive cycles.
- WRITE accepted in the cycle where sd_data_oe=1: bus contention, code 5. The write is still performed.
- PRECHARGE:
  - sd_addr[10]=1 closes all banks, otherwise bank sd_ba.
  - Precharging an idle bank is legal.
  - The precharge counter of each affected bank clears.
- AUTO_REFRESH:
  - Any bank open: code 1, count unchanged.
  - Otherwise refresh_cnt increments, saturating at 0xFFFF.
  - Legal with mode_valid=0.
- Errors:
  - err is set on the first error and err_code holds that first code.
  - Later errors are ignored.
  - Cleared only by reset_n.

Test Plan:
- LOAD_MODE sd_addr=0x220, ACTIVE ba=1 row=0x0123, two NOPs, WRITE col=0x045 data=0xBEEF dqm=00, READ col=0x045 → sd_data_oe high for one cycle, sd_data_out=0xBEEF sampled at edge N+2, err=0.
- Same sequence with CL=3 (sd_addr=0x230) and WRITE dqm=10 over a prior word 0x1111 → read returns 0x11EF at edge N+3.
- READ one cycle after ACTIVE (RCD=2) → err=1, err_code=3, data still returned; a second violation leaves err_code=3.
- READ to an idle bank, and ACTIVE to an open bank, each in a fresh reset → err_code=1; READ with no data returned.
- Three AUTO_REFRESH with all banks idle → refresh_cnt=3; ACTIVE then AUTO_REFRESH → refresh_cnt stays 3, err_code=1.
- Two back-to-back READs at CL=2, then reset_n low one cycle after the second READ → oe drops immediately, no further data driven, mode_valid=0.
